// File: rtl/fp16_add_engine.sv
`default_nettype none
// ============================================================================
//  Module   : fp16_add_engine
//  Purpose  : Self-sequencing FP16 (1-5-10, bias 15) adder over a private
//             256x8 memory; optional macro FP16_ADD_ROUND_NEAREST_EN selects
//             round-to-nearest-even instead of truncation.
//  Revision : 1.0 - initial release
// ============================================================================

module fp16_add_mem #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_wdata,
    output logic [7:0]        o_rdata
);
    logic [7:0] my_memory [0:MEM_DEPTH-1];

    assign o_rdata = my_memory[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            my_memory[i_addr] <= i_wdata;
        end
    end
endmodule

module fp16_add_engine #(
    parameter int OP_BASE   = 128,
    parameter int RES_BASE  = 132,
    parameter int MEM_DEPTH = 256
) (
    input  logic clk,
    input  logic reset,
    output logic done
);
    localparam int c_AW = $clog2(MEM_DEPTH);
    localparam logic [c_AW-1:0] c_A_MSB   = c_AW'(OP_BASE);
    localparam logic [c_AW-1:0] c_A_LSB   = c_AW'(OP_BASE + 1);
    localparam logic [c_AW-1:0] c_B_MSB   = c_AW'(OP_BASE + 2);
    localparam logic [c_AW-1:0] c_B_LSB   = c_AW'(OP_BASE + 3);
    localparam logic [c_AW-1:0] c_RES_MSB = c_AW'(RES_BASE);
    localparam logic [c_AW-1:0] c_RES_LSB = c_AW'(RES_BASE + 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_RD0, ST_RD1, ST_RD2, ST_RD3,
        ST_ALIGN, ST_ADD, ST_NORM, ST_WR0, ST_WR1, ST_DONE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_done;
    logic [15:0]       r_op_a, r_op_b, r_result;
    logic              r_sign, r_sub;
    logic [4:0]        r_exp;
    logic [13:0]       r_sig_l, r_sig_s;
    logic [14:0]       r_sum;

    logic [c_AW-1:0]   w_addr;
    logic              w_we;
    logic [7:0]        w_wdata, w_rdata;

    fp16_add_mem #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(c_AW)) data_mem1 (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    assign done = r_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr      = c_A_MSB;
        w_we        = 1'b0;
        w_wdata     = r_result[15:8];
        case (r_state)
            ST_IDLE:  w_state_nxt = ST_RD0;
            ST_RD0:   begin w_addr = c_A_MSB; w_state_nxt = ST_RD1; end
            ST_RD1:   begin w_addr = c_A_LSB; w_state_nxt = ST_RD2; end
            ST_RD2:   begin w_addr = c_B_MSB; w_state_nxt = ST_RD3; end
            ST_RD3:   begin w_addr = c_B_LSB; w_state_nxt = ST_ALIGN; end
            ST_ALIGN: w_state_nxt = ST_ADD;
            ST_ADD:   w_state_nxt = ST_NORM;
            ST_NORM:  w_state_nxt = ST_WR0;
            ST_WR0: begin
                w_addr      = c_RES_MSB;
                w_we        = 1'b1;
                w_wdata     = r_result[15:8];
                w_state_nxt = ST_WR1;
            end
            ST_WR1: begin
                w_addr      = c_RES_LSB;
                w_we        = 1'b1;
                w_wdata     = r_result[7:0];
                w_state_nxt = ST_DONE;
            end
            ST_DONE:  w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Alignment: larger magnitude by {E,F}; smaller gets G/R bits plus sticky
    logic        w_a_big;
    logic [15:0] w_big, w_sml;
    logic [10:0] w_sig_big, w_sig_sml;
    logic [4:0]  w_diff;
    logic [3:0]  w_shamt;
    logic [26:0] w_shift;
    logic [13:0] w_sml_al;

    always_comb begin
        w_a_big   = (r_op_a[14:0] >= r_op_b[14:0]);
        w_big     = w_a_big ? r_op_a : r_op_b;
        w_sml     = w_a_big ? r_op_b : r_op_a;
        w_sig_big = {(w_big[14:10] != 5'd0), w_big[9:0]};
        w_sig_sml = {(w_sml[14:10] != 5'd0), w_sml[9:0]};
        w_diff    = w_big[14:10] - w_sml[14:10];
        w_shamt   = (w_diff > 5'd14) ? 4'd14 : w_diff[3:0];
        w_shift   = {w_sig_sml, 16'd0} >> w_shamt;
        w_sml_al  = {w_shift[26:14], |w_shift[13:0]};
    end

    // Normalisation and result packing
    logic [3:0]        w_lz;
    logic signed [6:0] w_exp;
    logic [9:0]        w_frac;
    logic [15:0]       w_result;
`ifdef FP16_ADD_ROUND_NEAREST_EN
    logic [13:0]       w_ext;
    logic [11:0]       w_rnd;
`endif

    always_comb begin
        w_lz = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (r_sum[i]) w_lz = 4'(13 - i);
        end
        if (r_sum[14]) w_exp = $signed({2'b00, r_exp}) + 7'sd1;
        else           w_exp = $signed({2'b00, r_exp}) - $signed({3'b000, w_lz});
`ifdef FP16_ADD_ROUND_NEAREST_EN
        if (r_sum[14]) w_ext = {r_sum[14:4], r_sum[3], r_sum[2], |r_sum[1:0]};
        else           w_ext = r_sum[13:0] << w_lz;
        w_rnd = {1'b0, w_ext[13:3]} + {11'd0, w_ext[2] & (w_ext[1] | w_ext[0] | w_ext[3])};
        if (w_rnd[11]) begin
            w_frac = w_rnd[10:1];
            w_exp  = w_exp + 7'sd1;
        end else begin
            w_frac = w_rnd[9:0];
        end
`else
        if (r_sum[14]) w_frac = r_sum[13:4];
        else           w_frac = 10'((r_sum[13:0] << w_lz) >> 3);
`endif
        if (r_sum == 15'd0)      w_result = 16'h0000;
        else if (w_exp > 7'sd31) w_result = {r_sign, 15'h7FFF};
        else if (w_exp < 7'sd1)  w_result = 16'h0000;
        else                     w_result = {r_sign, w_exp[4:0], w_frac};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op_a   <= 16'd0;
            r_op_b   <= 16'd0;
            r_sign   <= 1'b0;
            r_sub    <= 1'b0;
            r_exp    <= 5'd0;
            r_sig_l  <= 14'd0;
            r_sig_s  <= 14'd0;
            r_sum    <= 15'd0;
            r_result <= 16'd0;
        end else begin
            case (r_state)
                ST_RD0: r_op_a[15:8] <= w_rdata;
                ST_RD1: r_op_a[7:0]  <= w_rdata;
                ST_RD2: r_op_b[15:8] <= w_rdata;
                ST_RD3: r_op_b[7:0]  <= w_rdata;
                ST_ALIGN: begin
                    r_sig_l <= {w_sig_big, 3'b000};
                    r_sig_s <= w_sml_al;
                    r_exp   <= w_big[14:10];
                    r_sign  <= w_big[15];
                    r_sub   <= r_op_a[15] ^ r_op_b[15];
                end
                ST_ADD: begin
                    if (r_sub) r_sum <= {1'b0, r_sig_l} - {1'b0, r_sig_s};
                    else       r_sum <= {1'b0, r_sig_l} + {1'b0, r_sig_s};
                end
                ST_NORM: r_result <= w_result;
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fp16_add_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp16_add_engine
//  Purpose  : Scoreboard bench for fp16_add_engine (memory backdoor access).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp16_add_engine;
    logic clk;
    logic reset;
    logic done;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  ref_lo [0:127];

    fp16_add_engine dut (
        .clk   (clk),
        .reset (reset),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Exact integer reference: value * 2^25 = sig * 2^E
    function automatic logic [15:0] fp16_model(input logic [15:0] a, input logic [15:0] b);
        longint ma, mb, s, m, sg, rem;
        int p, er;
        logic sn;
        ma = longint'({(a[14:10] != 5'd0), a[9:0]}) << a[14:10];
        mb = longint'({(b[14:10] != 5'd0), b[9:0]}) << b[14:10];
        if (a[15]) ma = -ma;
        if (b[15]) mb = -mb;
        s = ma + mb;
        if (s == 0) return 16'h0000;
        sn = (s < 0);
        m  = sn ? -s : s;
        p  = 0;
        for (int i = 0; i < 63; i++) if (m[i]) p = i;
        er = p - 10;
        if (er < 1) return 16'h0000;
        sg  = m >> er;
        rem = m - (sg << er);
`ifdef FP16_ADD_ROUND_NEAREST_EN
        if (rem > (longint'(1) << (er - 1)) || (rem == (longint'(1) << (er - 1)) && sg[0])) begin
            sg = sg + 1;
            if (sg == 2048) begin
                sg = 1024;
                er = er + 1;
            end
        end
`else
        if (rem < 0) sg = 0;
`endif
        if (er > 31) return {sn, 15'h7FFF};
        return {sn, er[4:0], sg[9:0]};
    endfunction

    function automatic real fp16_real(input logic [15:0] v);
        real r;
        r = real'({(v[14:10] != 5'd0), v[9:0]}) / 1024.0;
        for (int i = 0; i < int'(v[14:10]); i++) r = r * 2.0;
        r = r / 32768.0;
        return v[15] ? -r : r;
    endfunction

    task automatic load_ops(input logic [15:0] a, input logic [15:0] b);
        dut.data_mem1.my_memory[128] = a[15:8];
        dut.data_mem1.my_memory[129] = a[7:0];
        dut.data_mem1.my_memory[130] = b[15:8];
        dut.data_mem1.my_memory[131] = b[7:0];
    endtask

    // Async reset off-edge, preload, release, verify 10-clock latency and result
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e,
                          input string tag, output logic [15:0] got);
        logic [15:0] want;
        @(negedge clk);
        #1 reset = 1'b0;
        #1 check_eq({tag, "_done_async_clr"}, 32'(done), 32'd0);
        load_ops(a, b);
        dut.data_mem1.my_memory[132] = ~e[15:8];
        dut.data_mem1.my_memory[133] = ~e[7:0];
        exp_q.push_back(e);
        @(negedge clk);
        reset = 1'b1;
        repeat (9) @(posedge clk);
        #1 check_eq({tag, "_done_early"}, 32'(done), 32'd0);
        @(posedge clk);
        #1 check_eq({tag, "_done_at_10"}, 32'(done), 32'd1);
        want = exp_q.pop_front();
        got  = {dut.data_mem1.my_memory[132], dut.data_mem1.my_memory[133]};
        check_eq(tag, 32'(got), 32'(want));
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
    } vec_t;

    initial begin
        vec_t        vecs[$];
        logic [15:0] got, a, b, e;
        real         ra, rr, err;
        int          lo_bad;

        reset = 1'b0;
        for (int i = 0; i < 128; i++) begin
            ref_lo[i] = 8'(i * 37 + 11);
            dut.data_mem1.my_memory[i] = ref_lo[i];
        end
        repeat (3) @(posedge clk);
        #1 check_eq("reset_done", 32'(done), 32'd0);

        vecs.push_back('{16'h1A04, 16'h1A04, 16'h1E04});
        vecs.push_back('{16'h4204, 16'h4204, 16'h4604});
        vecs.push_back('{16'h4A10, 16'h4204, 16'h4B91});
        vecs.push_back('{16'h4204, 16'hC204, 16'h0000});
        vecs.push_back('{16'h3C00, 16'hB800, 16'h3800});
        vecs.push_back('{16'h7FFF, 16'h7FFF, 16'h7FFF});
`ifdef FP16_ADD_ROUND_NEAREST_EN
        vecs.push_back('{16'h3C00, 16'h1001, 16'h3C01});
`else
        vecs.push_back('{16'h3C00, 16'h1001, 16'h3C00});
`endif
        vecs.push_back('{16'h0000, 16'h0000, 16'h0000});
        vecs.push_back('{16'hFBFF, 16'hFBFF, 16'hFFFF});
        vecs.push_back('{16'h0400, 16'h8001, 16'h0000});
        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].r, $sformatf("dir%0d", i), got);

        repeat (5) @(posedge clk);
        #1 check_eq("done_held", 32'(done), 32'd1);

        // Abort after the MSB write: MSB updated, LSB keeps its old byte
        @(negedge clk);
        #1 reset = 1'b0;
        load_ops(16'h4204, 16'h4204);
        dut.data_mem1.my_memory[132] = 8'hAA;
        dut.data_mem1.my_memory[133] = 8'hBB;
        @(negedge clk);
        reset = 1'b1;
        repeat (9) @(posedge clk);
        #2 reset = 1'b0;
        #1 check_eq("abort9_done", 32'(done), 32'd0);
        check_eq("abort9_msb", 32'(dut.data_mem1.my_memory[132]), 32'h46);
        check_eq("abort9_lsb", 32'(dut.data_mem1.my_memory[133]), 32'hBB);

        // Abort at cycle 6, then restart with new operands
        load_ops(16'h1A04, 16'h1A04);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #2 reset = 1'b0;
        #1 check_eq("abort6_done", 32'(done), 32'd0);
        run_op(16'h3C00, 16'hB800, 16'h3800, "restart", got);

        for (int n = 0; n < 25; n++) begin
            a = {1'($urandom), 5'($urandom_range(5, 25)), 10'($urandom)};
            b = {1'($urandom), 5'($urandom_range(5, 25)), 10'($urandom)};
            e = fp16_model(a, b);
            run_op(a, b, e, $sformatf("rnd%0d", n), got);
            ra = fp16_real(a) + fp16_real(b);
            rr = fp16_real(got);
            err = (rr > ra) ? (rr - ra) : (ra - rr);
            if (!(got == 16'h0000 && ra != 0.0)) begin
                check_eq($sformatf("rnd%0d_within_1pct", n),
                         32'(err <= 0.01 * ((ra < 0.0) ? -ra : ra)), 32'd1);
            end
        end

        lo_bad = 0;
        for (int i = 0; i < 128; i++) begin
            if (dut.data_mem1.my_memory[i] !== ref_lo[i]) lo_bad++;
        end
        check_eq("low_mem_untouched", 32'(lo_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fp16_add_engine.md
Name: fp16_add_engine

Overview:
- Self-sequencing half-precision (1-5-10, bias 15) floating-point adder with a private 256x8 data memory.
- After reset is released, it reads two operands from fixed memory bytes, adds them, writes the 16-bit result back to memory, and raises done.
- It is the compute block under the float-to-float top level. The bench preloads and inspects the memory by hierarchical backdoor access: instance data_mem1, array my_memory[0:255] of 8-bit words.

Parameters:
- OP_BASE, 128, byte address of operand 1 MSB. Operand 1 LSB is at +1, operand 2 MSB at +2, operand 2 LSB at +3.
- RES_BASE, 132, byte address of result MSB. Result LSB is at +1.
- MEM_DEPTH, 256, number of bytes in data_mem1.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset. Low = held in reset; high = run.
- done  output  1  high when the result has been written; held until reset is asserted.

Behaviour:
- Reset (reset low):
  - FSM goes to IDLE and done = 0 immediately, without waiting for a clock edge.
  - All datapath registers are cleared.
  - The contents of data_mem1 are NOT cleared. Operands are preloaded during reset.
- Memory:
  - Asynchronous (combinational) read, synchronous write.
  - Big-endian byte order: MSB holds bits [15:8].
- FSM sequence, one state per clock, starting at the first rising edge after reset goes high:
  - RD0 → RD1 → RD2 → RD3 → ALIGN → ADD → NORM → WR0 → WR1 → DONE.
  - done is registered high on the 10th rising edge after release, then stays in DONE.
  - Latency is fixed and independent of the data.
- Operand decode:
  - sign = bit15, E = bits[14:10], F = bits[9:0].
  - Significand = {E != 0, F}, i.e. 11 bits.
  - Value = sig/1024 × 2^(E−15). E = 0 gives a hidden bit of 0 with exponent −15.
  - E = 31 is an ordinary exponent (+16): no Inf/NaN handling.
- ALIGN:
  - The operand with the smaller magnitude (compare {E,F}) has its significand right-shifted by the exponent difference.
  - Three extra bits are kept: guard, round, sticky.
  - Shift is saturated at 14.
- ADD:
  - Equal signs: add magnitudes; result sign = common sign.
  - Different signs: larger magnitude minus smaller; result sign = sign of the larger.
- NORM:
  - On carry-out, shift right 1 and increment the exponent.
  - Otherwise, a leading-one detector left-shifts so the hidden bit is set, decrementing the exponent.
- Rounding: truncation (toward zero); the extra bits are discarded.
- Boundary cases:
  - Exact zero result (cancellation or 0+0) → 0x0000 (+0).
  - Biased result exponent > 31 → saturate to {sign, 0x7FFF}.
  - Biased result exponent < 1 after normalisation → flush to 0x0000.
- Reset asserted mid-operation:
  - done = 0 immediately; the sequence restarts from RD0 on the next release.
  - Result bytes already written remain.

Optional Feature:
- Macro: FP16_ADD_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even using the guard, round and sticky bits. A rounding carry renormalises and increments the exponent, then the overflow rule applies. Latency is unchanged: rounding is folded into NORM.
- Undefined: truncation, as specified above.

Test Plan:
- mem[128..131] = 1A 04 1A 04, release reset → done high after 10 clocks, mem[132..133] = 1E 04.
- Operands 0x4204 + 0x4204 → 0x4604. Operands 0x4A10 + 0x4204 → 0x4B91 (exact, alignment by 2).
- Operands 0x4204 + 0xC204 → 0x0000. Operands 0x3C00 + 0xB800 → 0x3800 (1.0 − 0.5).
- Operands 0x7FFF + 0x7FFF → 0x7FFF (saturation). Operands 0x3C00 + 0x1001 → 0x3C00 without the macro, 0x3C01 with FP16_ADD_ROUND_NEAREST_EN.
- Pull reset low at cycle 6 → done = 0 asynchronously. Change operands in memory, release → new correct result, done after 10 clocks. Memory bytes 0..127 unchanged throughout.
- 25 random operand pairs → result within 1% of the real-valued sum and bit-exact to a software model of the rules above; done held high until reset.
